signal_conflict_monitor: RTL
============================

SIGNAL_CONFLICT_MONITOR -- requirements
Module: signal_conflict_monitor

Interface
REQ-001 Parameter GREEN_MIN, default 8: minimum legal green dwell, in cycles.
REQ-002 Parameter GREEN_MAX, default 8: maximum legal green dwell, in cycles.
REQ-003 Parameter YELLOW_MIN, default 4: minimum legal yellow dwell, in cycles.
REQ-004 Parameter YELLOW_MAX, default 4: maximum legal yellow dwell, in cycles.
REQ-005 Parameter ALLRED_MAX, default 0: maximum all-red gap between yellow and the next green; 0 means no gap is allowed.
REQ-006 clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-007 rst  input  1: synchronous reset, active-high.
REQ-008 n_light, s_light, e_light, w_light  input  3 each: approach aspects; 100 = red, 010 = yellow, 001 = green.
REQ-009 fault  output  1: latched fault indication.
REQ-010 fault_code  output  3: code of the first fault detected; 0 = none.
REQ-011 active_dir  output  2: approach currently holding right-of-way; 0 = N, 1 = S, 2 = E, 3 = W.
REQ-012 active_valid  output  1: asserted when active_dir is meaningful.
REQ-013 cycle_done  output  1: one-cycle pulse when a full N-S-E-W rotation completes.

Function
REQ-014 Sampling: inputs SHALL be sampled on every rising clk edge.
REQ-015 Fault latency: a violation present at edge k SHALL be visible on fault and fault_code immediately after edge k.
REQ-016 FSM states: SYNC, GREEN, YELLOW, ALLRED, FAULT.
REQ-017 Dwell counter: 5-bit, saturating; it SHALL hold the number of consecutive samples of the current aspect, counting the first sample as 1.
REQ-018 Code 1 (encoding): any light not in {100, 010, 001} SHALL raise code 1, checked in every state except FAULT.
REQ-019 Code 2 (conflict): more than one approach non-red in the same sample SHALL raise code 2, checked in every state except FAULT.
REQ-020 Priority: when violations coincide, code 1 SHALL take precedence over code 2, and code 2 over codes 3-7.
REQ-021 SYNC: on the first sample with any green, the FSM SHALL enter GREEN for that approach with dwell = 1 and set the first-green flag.
REQ-022 First-green flag: the first green after SYNC SHALL be exempt from the GREEN_MIN check only.
REQ-023 GREEN, same approach still green: dwell increments; dwell reaching GREEN_MAX+1 SHALL raise code 5.
REQ-024 GREEN, same approach turns yellow: dwell < GREEN_MIN (not exempt) SHALL raise code 4; otherwise go to YELLOW with dwell = 1.
REQ-025 GREEN, any other change (all-red, or another approach non-red): SHALL raise code 3.
REQ-026 YELLOW, same approach still yellow: dwell increments; dwell reaching YELLOW_MAX+1 SHALL raise code 7.
REQ-027 YELLOW, all lights red: dwell < YELLOW_MIN SHALL raise code 6; ALLRED_MAX = 0 SHALL raise code 7; otherwise go to ALLRED with dwell = 1.
REQ-028 YELLOW, next approach (dir+1 mod 4) turns green: dwell < YELLOW_MIN SHALL raise code 6; otherwise go to GREEN for that approach with dwell = 1.
REQ-029 YELLOW, any other change (same approach green, or a non-next approach non-red): SHALL raise code 3.
REQ-030 ALLRED, still all red: dwell increments; dwell reaching ALLRED_MAX+1 SHALL raise code 7.
REQ-031 ALLRED, next approach turns green: go to GREEN with dwell = 1.
REQ-032 ALLRED, any other non-red aspect: SHALL raise code 3.
REQ-033 cycle_done: SHALL pulse for exactly one cycle on entry to GREEN with dir = N arriving from W yellow or W all-red; it SHALL NOT pulse on entry from SYNC.
REQ-034 active_valid: SHALL be 1 in GREEN, YELLOW and ALLRED (active_dir = last green approach) and 0 in SYNC and FAULT.
REQ-035 FAULT: on any fault, fault = 1 and fault_code = the winning code; both SHALL hold until rst; inputs SHALL be ignored while in FAULT.

Reset
REQ-036 While rst = 1, the FSM SHALL go to SYNC and set fault = 0, fault_code = 0, active_dir = 0, active_valid = 0, cycle_done = 0, dwell = 0, and clear the first-green flag.
REQ-037 rst SHALL win over any simultaneous violation or transition, including a reset asserted mid-operation or while in FAULT.
REQ-038 Inputs sampled while rst = 1 SHALL be ignored.

Verification
REQ-039 Legal rotation: rst, then N G8/Y4, S G8/Y4, E G8/Y4, W G8/Y4, repeated 3 times -> fault = 0 throughout; active_dir follows the green approach; cycle_done pulses once every 48 cycles.
REQ-040 Bad encoding: n_light = 011 mid-green -> fault = 1, fault_code = 1 on the next cycle; active_valid = 0.
REQ-041 Conflict plus encoding: n_light = 001 and e_light = 001 -> code 2; same sample also with w_light = 111 -> code 1.
REQ-042 Timing: after one legal rotation, N green for 5 samples then yellow -> code 4; separately, N green for 9 samples -> code 5 on the 9th sample; yellow for 3 samples then S green -> code 6.
REQ-043 Sequence: N yellow followed directly by E green -> code 3; separately, with ALLRED_MAX = 2, a 3-sample all-red gap -> code 7.
REQ-044 Reset recovery: latch code 5, then pulse rst for 1 cycle -> all outputs 0 on the next cycle; a legal rotation afterwards produces no fault, with the first green exempt from GREEN_MIN.

Source files
------------

// File: rtl/signal_conflict_monitor_if.sv
// Bundle between the four-approach lamp driver and the conflict monitor.
// The master side drives the approach aspects and reads the monitor
// status; the slave side is the monitor itself.
interface signal_conflict_monitor_if;
    logic [2:0] n_light;
    logic [2:0] s_light;
    logic [2:0] e_light;
    logic [2:0] w_light;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] active_dir;
    logic       active_valid;
    logic       cycle_done;

    modport master (
        output n_light, s_light, e_light, w_light,
        input  fault, fault_code, active_dir, active_valid, cycle_done
    );

    modport slave (
        input  n_light, s_light, e_light, w_light,
        output fault, fault_code, active_dir, active_valid, cycle_done
    );
endinterface

// File: rtl/signal_conflict_monitor.sv
// Traffic signal conflict monitor. It watches the four approach aspects,
// tracks the expected N-S-E-W green/yellow/all-red rotation, and latches the
// first illegal condition as a fault code that holds until reset.
module signal_conflict_monitor #(
    parameter int GREEN_MIN  = 8,
    parameter int GREEN_MAX  = 8,
    parameter int YELLOW_MIN = 4,
    parameter int YELLOW_MAX = 4,
    parameter int ALLRED_MAX = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    signal_conflict_monitor_if.slave bus
);
    typedef enum logic [2:0] {SYNC, GREEN, YELLOW, ALLRED, FAULT} state_t;

    localparam logic [2:0] CODE_ENCODING     = 3'd1;
    localparam logic [2:0] CODE_CONFLICT     = 3'd2;
    localparam logic [2:0] CODE_SEQUENCE     = 3'd3;
    localparam logic [2:0] CODE_GREEN_SHORT  = 3'd4;
    localparam logic [2:0] CODE_GREEN_LONG   = 3'd5;
    localparam logic [2:0] CODE_YELLOW_SHORT = 3'd6;
    localparam logic [2:0] CODE_OVERRUN      = 3'd7;

    state_t          state, state_n;
    logic [4:0]      dwell, dwell_n, dwell_inc;
    logic [1:0]      dir, dir_n, next_dir, green_dir;
    logic            first_green, first_green_n;
    logic            fault, fault_n;
    logic [2:0]      fault_code, fault_code_n, raise_code;
    logic            cycle_done, cycle_done_n;
    logic [3:0][2:0] lights;
    logic [3:0]      is_red, is_yellow, is_green, is_bad;
    logic            bad_encoding, conflict, all_red;

    // Index 0 = N, 1 = S, 2 = E, 3 = W, matching active_dir.
    assign lights = {bus.w_light, bus.e_light, bus.s_light, bus.n_light};

    // Classify every approach's aspect as red, yellow, green or malformed.
    always_comb begin
        is_red    = '0;
        is_yellow = '0;
        is_green  = '0;
        is_bad    = '0;
        for (int i = 0; i < 4; i++) begin
            is_red[i]    = (lights[i] == 3'b100);
            is_yellow[i] = (lights[i] == 3'b010);
            is_green[i]  = (lights[i] == 3'b001);
            is_bad[i]    = !(is_red[i] || is_yellow[i] || is_green[i]);
        end
    end

    assign bad_encoding = |is_bad;
    assign conflict     = ($countones(~is_red) > 1);
    assign all_red      = &is_red;
    assign dwell_inc    = (dwell == 5'd31) ? dwell : dwell + 5'd1;
    assign next_dir     = dir + 2'd1;

    // Find which approach went green while synchronising.
    always_comb begin
        green_dir = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (is_green[i]) begin
                green_dir = 2'(i);
            end
        end
    end

    // Next-state logic: follow the rotation and pick the winning fault code.
    always_comb begin
        state_n       = state;
        dwell_n       = dwell;
        dir_n         = dir;
        first_green_n = first_green;
        fault_n       = fault;
        fault_code_n  = fault_code;
        cycle_done_n  = 1'b0;
        raise_code    = 3'd0;

        if (state != FAULT) begin
            if (bad_encoding) begin
                raise_code = CODE_ENCODING;
            end else if (conflict) begin
                raise_code = CODE_CONFLICT;
            end else begin
                case (state)
                    SYNC: begin
                        if (|is_green) begin
                            state_n       = GREEN;
                            dir_n         = green_dir;
                            dwell_n       = 5'd1;
                            first_green_n = 1'b1;
                        end
                    end
                    GREEN: begin
                        if (is_green[dir]) begin
                            dwell_n = dwell_inc;
                            if (int'(dwell_inc) == GREEN_MAX + 1) begin
                                raise_code = CODE_GREEN_LONG;
                            end
                        end else if (is_yellow[dir]) begin
                            if (!first_green && int'(dwell) < GREEN_MIN) begin
                                raise_code = CODE_GREEN_SHORT;
                            end else begin
                                state_n       = YELLOW;
                                dwell_n       = 5'd1;
                                first_green_n = 1'b0;
                            end
                        end else begin
                            raise_code = CODE_SEQUENCE;
                        end
                    end
                    YELLOW: begin
                        if (is_yellow[dir]) begin
                            dwell_n = dwell_inc;
                            if (int'(dwell_inc) == YELLOW_MAX + 1) begin
                                raise_code = CODE_OVERRUN;
                            end
                        end else if (all_red) begin
                            if (int'(dwell) < YELLOW_MIN) begin
                                raise_code = CODE_YELLOW_SHORT;
                            end else if (ALLRED_MAX == 0) begin
                                raise_code = CODE_OVERRUN;
                            end else begin
                                state_n = ALLRED;
                                dwell_n = 5'd1;
                            end
                        end else if (is_green[next_dir]) begin
                            if (int'(dwell) < YELLOW_MIN) begin
                                raise_code = CODE_YELLOW_SHORT;
                            end else begin
                                state_n      = GREEN;
                                dir_n        = next_dir;
                                dwell_n      = 5'd1;
                                cycle_done_n = (next_dir == 2'd0);
                            end
                        end else begin
                            raise_code = CODE_SEQUENCE;
                        end
                    end
                    ALLRED: begin
                        if (all_red) begin
                            dwell_n = dwell_inc;
                            if (int'(dwell_inc) == ALLRED_MAX + 1) begin
                                raise_code = CODE_OVERRUN;
                            end
                        end else if (is_green[next_dir]) begin
                            state_n      = GREEN;
                            dir_n        = next_dir;
                            dwell_n      = 5'd1;
                            cycle_done_n = (next_dir == 2'd0);
                        end else begin
                            raise_code = CODE_SEQUENCE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        if (raise_code != 3'd0) begin
            state_n      = FAULT;
            fault_n      = 1'b1;
            fault_code_n = raise_code;
            cycle_done_n = 1'b0;
        end
    end

    // State register; reset overrides everything including a latched fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SYNC;
            dwell       <= 5'd0;
            dir         <= 2'd0;
            first_green <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= 3'd0;
            cycle_done  <= 1'b0;
        end else begin
            state       <= state_n;
            dwell       <= dwell_n;
            dir         <= dir_n;
            first_green <= first_green_n;
            fault       <= fault_n;
            fault_code  <= fault_code_n;
            cycle_done  <= cycle_done_n;
        end
    end

    assign bus.fault        = fault;
    assign bus.fault_code   = fault_code;
    assign bus.active_dir   = dir;
    assign bus.active_valid = (state == GREEN) || (state == YELLOW) || (state == ALLRED);
    assign bus.cycle_done   = cycle_done;
endmodule
